m72_region_loader: RTL
======================

// Module: m72_region_loader
// PURPOSE
//  Parametrised ROM download router: consumes the byte-serial ioctl stream, splits it into
//  NUM_REGIONS length-prefixed regions, remaps and routes each byte to SDRAM (req/ack) or to
//  a BRAM chip-select port. Sits between the HPS download interface and the SDRAM/BRAM
//  arbiters. Adds per-region plane interleave and error reporting.
// PARAMETERS
//  NUM_REGIONS     9       number of regions in the stream, loaded in index order 0..N-1
//  ADDR_W          25      byte address width
//  CS_W            4       BRAM chip-select width
//  REGION_BASE     0       [NUM_REGIONS*ADDR_W] SDRAM byte base per region, region 0 in LSBs
//  REGION_REORDER  0       [NUM_REGIONS] 1 = apply 4-plane 64-bit interleave
//  REGION_CS       0       [NUM_REGIONS*CS_W] nonzero = route region to BRAM with this CS
// PORTS
//  clk            in   1      system clock
//  reset          in   1      synchronous, active-high
//  ioctl_download in   1      download active
//  ioctl_wr       in   1      byte strobe, one cycle
//  ioctl_data     in   8      download byte
//  ioctl_wait     out  1      stall; high while an SDRAM write is pending
//  sdr_addr       out  ADDR_W SDRAM byte address
//  sdr_data       out  16     byte duplicated on both lanes
//  sdr_be         out  2      {addr[0], ~addr[0]}
//  sdr_req        out  1      write request, held until sdr_ack
//  sdr_ack        in   1      one-cycle completion
//  bram_addr      out  ADDR_W region offset (post-reorder), no base added
//  bram_data      out  8      byte
//  bram_wr        out  1      one-cycle write strobe
//  bram_cs        out  CS_W   REGION_CS of current region, 0 when bram_wr low
//  region_idx     out  $clog2(NUM_REGIONS+1)  current region
//  done           out  1      sticky: stream ended cleanly
//  error          out  1      sticky: protocol/format error
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0.
//  - Rising ioctl_download (any state): clear region_idx, offset, done, error; enter HDR.
//  - States: IDLE, HDR, DATA, WACK, DONE.
//  - HDR: collect 4 bytes little-endian into 32-bit LEN. After 4th byte: LEN==0 -> region_idx++,
//    stay HDR (or DONE if region_idx reaches NUM_REGIONS); else offset=0, enter DATA.
//  - DATA: per ioctl_wr byte at offset o, compute o' (below). SDRAM region: next cycle
//    sdr_req=1, sdr_addr=base+o', ioctl_wait=1, state WACK. BRAM region: next cycle bram_wr=1
//    for one cycle, no stall. Then o++; at o==LEN region_idx++, back to HDR, or DONE at N.
//  - WACK: hold addr/data/req stable; on sdr_ack drop req and ioctl_wait next cycle; return to
//    DATA/HDR per counters. ack in same cycle as req rise is legal (min 1-cycle WACK).
//  - Latency: byte accepted cycle t -> sdr_req or bram_wr at t+1. Max one byte in flight.
//  - Reorder (REGION_REORDER=1): P=LEN/4; p=o/P, i=o%P; o'=(i>>1)*8+p*2+(i&1). LEN must be a
//    power of two >=8, else error at header end and region routed without reorder.
//  - Errors (sticky, processing continues where defined): ioctl_wr while ioctl_wait high (byte
//    dropped); ioctl_wr in DONE (ignored); ioctl_download falls in HDR mid-header or DATA with
//    o<LEN; bad reorder length. Address overflow beyond ADDR_W wraps silently.
//  - ioctl_download falls at region boundary with region_idx==NUM_REGIONS: done=1. Falls while
//    in WACK: complete the pending write first, then evaluate.
//  - reset mid-transfer: sdr_req dropped immediately; downstream must tolerate abandoned req.
// CONFIGURATION
//  M72_LOADER_CHECKSUM_EN: adds output checksum[15:0] = mod-2^16 sum of all data bytes of the
//  most recently completed region, updated the cycle its last byte is accepted; cleared on
//  download start. Without the macro: port absent, no adder logic.
// TESTING
//  - N=2, R0 SDRAM base 0x100000 LEN=4 bytes 11 22 33 44, ack after 3 cycles -> writes to
//    0x100000..03, be 01/10/01/10, ioctl_wait high each pending write, done=1 at end.
//  - R0 REORDER LEN=16 bytes 0..15 -> byte 4 (p=1,i=0) to base+2, byte 13 (p=3,i=1) to base+7.
//  - R0 LEN=0, R1 CS=4'b0100 LEN=2 bytes AA BB -> bram_wr pulses, addr 0,1, cs 0100, no stall.
//  - ioctl_wr during ioctl_wait -> byte dropped, error=1; download drop at o=3 of LEN=8 -> error=1.
//  - REORDER region LEN=12 -> error=1 after header; reset asserted during WACK -> sdr_req=0 next cycle.
//  - With M72_LOADER_CHECKSUM_EN: bytes FF FF 02 -> checksum=0x0200.

Source files
------------

// File: rtl/m72_region_loader.sv
// m72_region_loader
//   Splits the byte-serial ioctl download stream into NUM_REGIONS regions.
//   Each region starts with a 4-byte little-endian length header followed by
//   that many data bytes. A data byte goes either to SDRAM (req/ack handshake,
//   stalls the stream through ioctl_wait) or to a BRAM chip-select port (single
//   strobe, no stall). Regions can optionally have a 4-plane 64-bit interleave
//   applied to their byte offsets.
//
// Ports
//   clk, reset                  system clock, synchronous active-high reset
//   ioctl_download/wr/data      download stream in; ioctl_wait stalls it
//   sdr_addr/data/be/req/ack    SDRAM byte write port
//   bram_addr/data/wr/cs        BRAM write port (region offset, no base)
//   region_idx                  region currently being loaded
//   done, error                 sticky status, cleared when a download starts
//   checksum                    only with M72_LOADER_CHECKSUM_EN: mod-2^16 sum
//                               of the bytes of the last completed region
//
// Configuration macro: M72_LOADER_CHECKSUM_EN
module m72_region_loader #(
  parameter int                              NUM_REGIONS    = 9,
  parameter int                              ADDR_W         = 25,
  parameter int                              CS_W           = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]   REGION_BASE    = '0,
  parameter logic [NUM_REGIONS-1:0]          REGION_REORDER = '0,
  parameter logic [NUM_REGIONS*CS_W-1:0]     REGION_CS      = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               ioctl_download,
  input  logic                               ioctl_wr,
  input  logic [7:0]                         ioctl_data,
  output logic                               ioctl_wait,
  output logic [ADDR_W-1:0]                  sdr_addr,
  output logic [15:0]                        sdr_data,
  output logic [1:0]                         sdr_be,
  output logic                               sdr_req,
  input  logic                               sdr_ack,
  output logic [ADDR_W-1:0]                  bram_addr,
  output logic [7:0]                         bram_data,
  output logic                               bram_wr,
  output logic [CS_W-1:0]                    bram_cs,
  output logic [$clog2(NUM_REGIONS+1)-1:0]   region_idx,
  output logic                               done,
  output logic                               error
`ifdef M72_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]                        checksum
`endif
);

  localparam int RW = $clog2(NUM_REGIONS+1);

  typedef enum logic [2:0] {IDLE, HDR, DATA, WACK, DONE} state_t;

  function automatic logic [ADDR_W-1:0] region_base(input logic [RW-1:0] idx);
    region_base = '0;
    for (int r = 0; r < NUM_REGIONS; r++)
      if (idx == RW'(r)) region_base = REGION_BASE[r*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [CS_W-1:0] region_cs(input logic [RW-1:0] idx);
    region_cs = '0;
    for (int r = 0; r < NUM_REGIONS; r++)
      if (idx == RW'(r)) region_cs = REGION_CS[r*CS_W +: CS_W];
  endfunction

  function automatic logic region_reorder(input logic [RW-1:0] idx);
    region_reorder = 1'b0;
    for (int r = 0; r < NUM_REGIONS; r++)
      if (idx == RW'(r)) region_reorder = REGION_REORDER[r];
  endfunction

  state_t            state_q, state_d;
  logic [RW-1:0]     region_idx_q, region_idx_d;
  logic [31:0]       offset_q, offset_d;
  logic [31:0]       len_q, len_d;
  logic [1:0]        hdr_cnt_q, hdr_cnt_d;
  logic              dl_q;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              reorder_en_q, reorder_en_d;
  logic [4:0]        plog_q, plog_d;
  logic              sdr_req_q, sdr_req_d;
  logic [ADDR_W-1:0] sdr_addr_q, sdr_addr_d;
  logic [7:0]        sdr_data_q, sdr_data_d;
  logic              bram_wr_q, bram_wr_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [7:0]        bram_data_q, bram_data_d;
  logic [CS_W-1:0]   bram_cs_q, bram_cs_d;
`ifdef M72_LOADER_CHECKSUM_EN
  logic [15:0]       sum_q, sum_d;
  logic [15:0]       checksum_q, checksum_d;
`endif

  logic              dl_rise, dl_fall;
  logic [31:0]       new_len, p_idx, i_idx;
  logic [4:0]        len_lg;
  logic [ADDR_W-1:0] o_map;
  logic [RW-1:0]     idx_inc;
  logic              last_byte;

  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;
  // Header bytes shift in from the top so the first byte lands in [7:0].
  assign new_len = {ioctl_data, len_q[31:8]};
  assign idx_inc = region_idx_q + RW'(1);
  assign last_byte = (offset_q + 32'd1) == len_q;

  // Interleave: plane size P = LEN/4 = 2^plog; p = o/P, i = o%P.
  assign p_idx = offset_q >> plog_q;
  assign i_idx = offset_q & ((32'd1 << plog_q) - 32'd1);
  assign o_map = reorder_en_q
               ? ADDR_W'(((i_idx >> 1) << 3) + (p_idx << 1) + (i_idx & 32'd1))
               : ADDR_W'(offset_q);

  always_comb begin
    len_lg = '0;
    for (int b = 0; b < 32; b++)
      if (new_len[b]) len_lg = 5'(b);
  end

  always_comb begin
    state_d      = state_q;
    region_idx_d = region_idx_q;
    offset_d     = offset_q;
    len_d        = len_q;
    hdr_cnt_d    = hdr_cnt_q;
    done_d       = done_q;
    error_d      = error_q;
    reorder_en_d = reorder_en_q;
    plog_d       = plog_q;
    sdr_req_d    = sdr_req_q;
    sdr_addr_d   = sdr_addr_q;
    sdr_data_d   = sdr_data_q;
    bram_wr_d    = 1'b0;
    bram_addr_d  = bram_addr_q;
    bram_data_d  = bram_data_q;
    bram_cs_d    = '0;
`ifdef M72_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
    checksum_d   = checksum_q;
`endif

    case (state_q)
      HDR: begin
        if (dl_fall) begin
          if (hdr_cnt_q != 2'd0) error_d = 1'b1;
          else if (region_idx_q == RW'(NUM_REGIONS)) done_d = 1'b1;
          state_d = IDLE;
        end else if (ioctl_wr) begin
          len_d     = new_len;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            if (new_len == 32'd0) begin
              region_idx_d = idx_inc;
              if (idx_inc == RW'(NUM_REGIONS)) state_d = DONE;
            end else begin
              offset_d     = '0;
              reorder_en_d = 1'b0;
              plog_d       = len_lg - 5'd2;
              if (region_reorder(region_idx_q)) begin
                // A bad length is flagged but the region still loads linearly.
                if (new_len >= 32'd8 && (new_len & (new_len - 32'd1)) == 32'd0)
                  reorder_en_d = 1'b1;
                else
                  error_d = 1'b1;
              end
`ifdef M72_LOADER_CHECKSUM_EN
              sum_d = '0;
`endif
              state_d = DATA;
            end
          end
        end
      end

      DATA: begin
        if (dl_fall) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (ioctl_wr) begin
          if (region_cs(region_idx_q) != '0) begin
            bram_wr_d   = 1'b1;
            bram_addr_d = o_map;
            bram_data_d = ioctl_data;
            bram_cs_d   = region_cs(region_idx_q);
            if (last_byte) state_d = (idx_inc == RW'(NUM_REGIONS)) ? DONE : HDR;
          end else begin
            sdr_req_d  = 1'b1;
            sdr_addr_d = region_base(region_idx_q) + o_map;
            sdr_data_d = ioctl_data;
            state_d    = WACK;
          end
`ifdef M72_LOADER_CHECKSUM_EN
          sum_d = sum_q + {8'd0, ioctl_data};
          if (last_byte) begin
            checksum_d = sum_q + {8'd0, ioctl_data};
            sum_d      = '0;
          end
`endif
          // Offset returns to 0 at region end; WACK uses that as the marker.
          if (last_byte) begin
            offset_d     = '0;
            region_idx_d = idx_inc;
          end else begin
            offset_d = offset_q + 32'd1;
          end
        end
      end

      WACK: begin
        if (ioctl_wr) error_d = 1'b1;
        if (sdr_ack) begin
          sdr_req_d = 1'b0;
          // A download that ended while the write was pending is judged now.
          if (!ioctl_download) begin
            if (region_idx_q == RW'(NUM_REGIONS)) done_d = 1'b1;
            else if (offset_q != 32'd0) error_d = 1'b1;
            state_d = IDLE;
          end else if (region_idx_q == RW'(NUM_REGIONS)) begin
            state_d = DONE;
          end else if (offset_q == 32'd0) begin
            state_d = HDR;
          end else begin
            state_d = DATA;
          end
        end
      end

      DONE: begin
        if (ioctl_wr) error_d = 1'b1;
        if (dl_fall) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: ;
    endcase

    if (dl_rise) begin
      state_d      = HDR;
      region_idx_d = '0;
      offset_d     = '0;
      len_d        = '0;
      hdr_cnt_d    = '0;
      done_d       = 1'b0;
      error_d      = 1'b0;
      sdr_req_d    = 1'b0;
      bram_wr_d    = 1'b0;
      bram_cs_d    = '0;
`ifdef M72_LOADER_CHECKSUM_EN
      sum_d        = '0;
      checksum_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      region_idx_q <= '0;
      offset_q     <= '0;
      len_q        <= '0;
      hdr_cnt_q    <= '0;
      dl_q         <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      reorder_en_q <= 1'b0;
      plog_q       <= '0;
      sdr_req_q    <= 1'b0;
      sdr_addr_q   <= '0;
      sdr_data_q   <= '0;
      bram_wr_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_data_q  <= '0;
      bram_cs_q    <= '0;
`ifdef M72_LOADER_CHECKSUM_EN
      sum_q        <= '0;
      checksum_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      region_idx_q <= region_idx_d;
      offset_q     <= offset_d;
      len_q        <= len_d;
      hdr_cnt_q    <= hdr_cnt_d;
      dl_q         <= ioctl_download;
      done_q       <= done_d;
      error_q      <= error_d;
      reorder_en_q <= reorder_en_d;
      plog_q       <= plog_d;
      sdr_req_q    <= sdr_req_d;
      sdr_addr_q   <= sdr_addr_d;
      sdr_data_q   <= sdr_data_d;
      bram_wr_q    <= bram_wr_d;
      bram_addr_q  <= bram_addr_d;
      bram_data_q  <= bram_data_d;
      bram_cs_q    <= bram_cs_d;
`ifdef M72_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
      checksum_q   <= checksum_d;
`endif
    end
  end

  assign ioctl_wait = sdr_req_q;
  assign sdr_req    = sdr_req_q;
  assign sdr_addr   = sdr_addr_q;
  assign sdr_data   = {sdr_data_q, sdr_data_q};
  assign sdr_be     = sdr_req_q ? {sdr_addr_q[0], ~sdr_addr_q[0]} : 2'b00;
  assign bram_wr    = bram_wr_q;
  assign bram_addr  = bram_addr_q;
  assign bram_data  = bram_data_q;
  assign bram_cs    = bram_cs_q;
  assign region_idx = region_idx_q;
  assign done       = done_q;
  assign error      = error_q;
`ifdef M72_LOADER_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule
